strobe_measure: RTL and testbench
=================================

STROBE_MEASURE -- requirements
Module: strobe_measure

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, giving the width of the delay, width and timeout counters.
REQ-002 The block SHALL have parameter MISS_W, default 16, giving the width of the missed-event counter.
REQ-003 Clock  input  1  single rising-edge clock for all logic.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  measurement enable; low forces IDLE.
REQ-006 myEvent  input  1  reference event, level, synchronous to Clock.
REQ-007 strobeIn  input  1  strobe under measurement, synchronous to Clock.
REQ-008 myTimeout  input  CNT_W  abort limit in cycles; 0 = no timeout.
REQ-009 measDelay  output  CNT_W  cycles from event rise to strobe rise, last good measurement.
REQ-010 measWidth  output  CNT_W  cycles strobeIn was high, last good measurement.
REQ-011 measValid  output  1  one-cycle pulse when measDelay/measWidth update.
REQ-012 measTimeout  output  1  one-cycle pulse on an aborted measurement.
REQ-013 busy  output  1  high while the state is not IDLE.
REQ-014 missedEvents  output  MISS_W  saturating count of event rises ignored while busy.

Function
REQ-015 Rise and fall edges SHALL be detected against a one-cycle registered copy of each input; an edge is "seen" in the cycle the input differs from its copy.
REQ-016 The FSM SHALL have states IDLE, WAIT_STROBE and IN_PULSE, plus one internal counter cnt.
REQ-017 IDLE, event rise with enable=1: go to WAIT_STROBE, cnt<=1; a strobe rise in the same cycle is ignored.
REQ-018 IDLE, strobe edges with no event rise: ignored.
REQ-019 WAIT_STROBE, strobe rise: measDelay capture value <= cnt, cnt<=1, go to IN_PULSE.
REQ-020 WAIT_STROBE, no strobe rise: cnt increments.
REQ-021 IN_PULSE, strobe fall: measDelay/measWidth update (measWidth=cnt), measValid=1 for exactly one cycle, go to IDLE; both outputs update together in the same cycle.
REQ-022 IN_PULSE, no strobe fall: cnt increments.
REQ-023 Latency: measValid SHALL rise one cycle after the cycle in which the strobe fall is seen.
REQ-024 Measured values: strobe rise seen one cycle after event rise gives measDelay=1; strobe high for N sampled cycles gives measWidth=N.
REQ-025 Timeout: with myTimeout!=0, cnt==myTimeout in WAIT_STROBE or IN_PULSE without the awaited edge gives measTimeout for one cycle, go to IDLE, measDelay/measWidth unchanged.
REQ-026 cnt SHALL saturate at all-ones and never wrap; a saturated capture is reported as all-ones.
REQ-027 Event rise while busy: ignored for measurement; missedEvents increments, saturating at all-ones.
REQ-028 Event rise in the same cycle that the FSM returns to IDLE: missed (counted), not started.
REQ-029 enable=0: synchronous return to IDLE next cycle, no measValid/measTimeout pulse, captures held.
REQ-030 measValid and measTimeout SHALL never be high in the same cycle.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 On Reset the block SHALL set state=IDLE, cnt=0, measDelay=0, measWidth=0, measValid=0, measTimeout=0, busy=0, missedEvents=0, and edge copies=0.
REQ-033 Reset mid-measurement SHALL abort the measurement immediately without a pulse; first event rise after deassertion starts cleanly.
REQ-034 An input already high at reset release SHALL be seen as a rise on the first clock.

Structure
REQ-035 A shared package (strobe_pkg) SHALL hold the state enum, CNT_W/MISS_W defaults and CNT_MAX constant.
REQ-036 One sub-module, edge_det (registered copy, rise/fall outputs), SHALL be instantiated twice.
REQ-037 The implementation SHALL be within 120-400 RTL lines with no other hierarchy.

Verification
REQ-038 Event rise at cycle 10, strobe high cycles 15-17 -> measValid pulse, measDelay=5, measWidth=3.
REQ-039 myTimeout=20, event, no strobe -> measTimeout pulse at cnt=20, busy falls, measDelay/measWidth unchanged.
REQ-040 Event and strobe rise in the same cycle from IDLE -> strobe ignored; the next strobe measures normally.
REQ-041 Second event rise during IN_PULSE -> missedEvents=1, first measurement unaffected.
REQ-042 Reset asserted asynchronously mid IN_PULSE -> all outputs 0 immediately, no measValid; the next event/strobe pair measures correctly.
REQ-043 enable dropped in WAIT_STROBE -> IDLE next cycle, no pulses; myTimeout=0 with strobe never arriving -> busy held, cnt saturates without wrap.

Source files
------------

// File: rtl/strobe_pkg.sv
// Shared types and constants for the strobe delay/width measurement block.
package strobe_pkg;
    localparam int CNT_W_DEF  = 32;
    localparam int MISS_W_DEF = 16;
    localparam logic [CNT_W_DEF-1:0] CNT_MAX = {CNT_W_DEF{1'b1}};

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_STROBE = 2'd1,
        IN_PULSE    = 2'd2
    } state_t;

    // Debug view: current state plus the edges seen in the previous cycle.
    typedef struct packed {
        state_t state;
        logic   ev_rise;
        logic   ev_fall;
        logic   st_rise;
        logic   st_fall;
    } dbg_t;
endpackage

// File: rtl/strobe_measure_if.sv
// Measurement bus: control/stimulus inputs and registered measurement results.
// Handshake: no valid/ready; measValid and measTimeout are one-cycle result strobes,
// measDelay/measWidth stay stable between strobes.
interface strobe_measure_if #(
    parameter int CNT_W  = 32,
    parameter int MISS_W = 16
);
    logic              enable;
    logic              myEvent;
    logic              strobeIn;
    logic [CNT_W-1:0]  myTimeout;
    logic [CNT_W-1:0]  measDelay;
    logic [CNT_W-1:0]  measWidth;
    logic              measValid;
    logic              measTimeout;
    logic              busy;
    logic [MISS_W-1:0] missedEvents;

    modport master (
        output enable, myEvent, strobeIn, myTimeout,
        input  measDelay, measWidth, measValid, measTimeout, busy, missedEvents
    );

    modport slave (
        input  enable, myEvent, strobeIn, myTimeout,
        output measDelay, measWidth, measValid, measTimeout, busy, missedEvents
    );
endinterface

// File: rtl/strobe_measure_edge_det.sv
// Rise/fall detector against a one-cycle registered copy; the copy resets low so
// an input already high at reset release reads as a rise on the first clock.
module edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);
    logic r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_q <= 1'b0;
        else       r_q <= i_d;
    end

    assign o_rise = i_d & ~r_q;
    assign o_fall = ~i_d & r_q;
endmodule

// File: rtl/strobe_measure.sv
// Measures event-rise-to-strobe-rise delay and strobe high width in clock cycles,
// with optional timeout abort and a saturating count of events missed while busy.
module strobe_measure
    import strobe_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int MISS_W = MISS_W_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    strobe_measure_if.slave   bus,
    output dbg_t              o_dbg
);
    localparam logic [CNT_W-1:0]  L_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  L_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [MISS_W-1:0] L_MISS_MAX = {MISS_W{1'b1}};
    localparam logic [MISS_W-1:0] L_MISS_ONE = {{(MISS_W-1){1'b0}}, 1'b1};

    logic w_ev_rise, w_ev_fall, w_st_rise, w_st_fall;

    edge_det u_ev_edge (
        .i_clk(Clock), .i_rst(Reset), .i_d(bus.myEvent),
        .o_rise(w_ev_rise), .o_fall(w_ev_fall)
    );
    edge_det u_st_edge (
        .i_clk(Clock), .i_rst(Reset), .i_d(bus.strobeIn),
        .o_rise(w_st_rise), .o_fall(w_st_fall)
    );

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0]  r_cap, w_cap_nxt;
    logic [CNT_W-1:0]  r_delay, w_delay_nxt;
    logic [CNT_W-1:0]  r_width, w_width_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_tmo, w_tmo_nxt;
    logic              r_busy;
    logic [MISS_W-1:0] r_missed;
    logic [3:0]        r_dbg_edges;
    logic              w_tmo_hit;
    logic [CNT_W-1:0]  w_cnt_inc;

    assign w_tmo_hit = (bus.myTimeout != '0) && (r_cnt == bus.myTimeout);
    assign w_cnt_inc = (r_cnt == L_CNT_MAX) ? r_cnt : r_cnt + L_CNT_ONE;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_cap       <= '0;
            r_delay     <= '0;
            r_width     <= '0;
            r_valid     <= 1'b0;
            r_tmo       <= 1'b0;
            r_busy      <= 1'b0;
            r_missed    <= '0;
            r_dbg_edges <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cap       <= w_cap_nxt;
            r_delay     <= w_delay_nxt;
            r_width     <= w_width_nxt;
            r_valid     <= w_valid_nxt;
            r_tmo       <= w_tmo_nxt;
            r_busy      <= (w_state_nxt != IDLE);
            r_dbg_edges <= {w_ev_rise, w_ev_fall, w_st_rise, w_st_fall};
            // Any event rise outside IDLE is lost, including the cycle the FSM leaves.
            if (w_ev_rise && (r_state != IDLE) && (r_missed != L_MISS_MAX))
                r_missed <= r_missed + L_MISS_ONE;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cap_nxt   = r_cap;
        w_delay_nxt = r_delay;
        w_width_nxt = r_width;
        w_valid_nxt = 1'b0;
        w_tmo_nxt   = 1'b0;
        if (!bus.enable) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_ev_rise) begin
                        w_state_nxt = WAIT_STROBE;
                        w_cnt_nxt   = L_CNT_ONE;
                    end
                end
                WAIT_STROBE: begin
                    if (w_st_rise) begin
                        w_cap_nxt   = r_cnt;
                        w_cnt_nxt   = L_CNT_ONE;
                        w_state_nxt = IN_PULSE;
                    end else if (w_tmo_hit) begin
                        w_tmo_nxt   = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end
                IN_PULSE: begin
                    if (w_st_fall) begin
                        w_delay_nxt = r_cap;
                        w_width_nxt = r_cnt;
                        w_valid_nxt = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = IDLE;
                    end else if (w_tmo_hit) begin
                        w_tmo_nxt   = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign bus.measDelay    = r_delay;
    assign bus.measWidth    = r_width;
    assign bus.measValid    = r_valid;
    assign bus.measTimeout  = r_tmo;
    assign bus.busy         = r_busy;
    assign bus.missedEvents = r_missed;

    assign o_dbg.state   = r_state;
    assign o_dbg.ev_rise = r_dbg_edges[3];
    assign o_dbg.ev_fall = r_dbg_edges[2];
    assign o_dbg.st_rise = r_dbg_edges[1];
    assign o_dbg.st_fall = r_dbg_edges[0];
endmodule

// File: tb/tb_strobe_measure.sv
// Directed bench for strobe_measure: a vector table of measurements plus
// hand-written sequences for reset, enable, missed-event and saturation corners.
module tb_strobe_measure;
  import strobe_pkg::*;

  localparam int CW = 8;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  dbg_t dbg;
  int   cyc = 0;

  strobe_measure_if #(.CNT_W(CW), .MISS_W(MW)) bus ();

  strobe_measure #(.CNT_W(CW), .MISS_W(MW)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus),
    .o_dbg (dbg)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- pulse monitor ----------------
  int valid_cnt = 0;
  int tmo_cnt   = 0;
  int both_cnt  = 0;
  int valid_cyc = -1;
  int tmo_cyc   = -1;

  always @(negedge clk) begin
    if (bus.measValid) begin
      valid_cnt = valid_cnt + 1;
      valid_cyc = cyc;
    end
    if (bus.measTimeout) begin
      tmo_cnt = tmo_cnt + 1;
      tmo_cyc = cyc;
    end
    if (bus.measValid && bus.measTimeout) both_cnt = both_cnt + 1;
  end

  // ---------------- scoreboard counters ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- drivers ----------------
  int ev_cyc   = 0;
  int fall_cyc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Event rise in cycle k, strobe rise in cycle k+gap, strobe high for width cycles.
  task automatic drive_meas(input int gap, input int width, input int tmo);
    bus.myTimeout = CW'(tmo);
    tick();
    bus.myEvent = 1'b1;
    ev_cyc = cyc;
    tick();
    bus.myEvent = 1'b0;
    repeat (gap - 1) tick();
    bus.strobeIn = 1'b1;
    repeat (width) tick();
    bus.strobeIn = 1'b0;
    fall_cyc = cyc;
  endtask

  task automatic wait_pulse(input string name, input int v0, input int t0);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      #1;
      if (valid_cnt + tmo_cnt > v0 + t0) begin
        got = 1'b1;
        break;
      end
    end
    check({name, "_pulse_seen"}, 64'(got), 64'd1);
    repeat (3) tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int gap;
    int width;
    int tmo;
    bit exp_valid;
    int exp_delay;
    int exp_width;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int v0, t0;
    bus.enable    = 1'b1;
    bus.myEvent   = 1'b0;
    bus.strobeIn  = 1'b0;
    bus.myTimeout = '0;

    // Timeout rows keep the previous row's measurement.
    vecs[0] = '{gap: 5,  width: 3,  tmo: 0,  exp_valid: 1, exp_delay: 5,  exp_width: 3};
    vecs[1] = '{gap: 1,  width: 1,  tmo: 0,  exp_valid: 1, exp_delay: 1,  exp_width: 1};
    vecs[2] = '{gap: 2,  width: 7,  tmo: 10, exp_valid: 1, exp_delay: 2,  exp_width: 7};
    vecs[3] = '{gap: 10, width: 4,  tmo: 10, exp_valid: 1, exp_delay: 10, exp_width: 4};
    vecs[4] = '{gap: 11, width: 4,  tmo: 10, exp_valid: 0, exp_delay: 10, exp_width: 4};
    vecs[5] = '{gap: 3,  width: 10, tmo: 10, exp_valid: 1, exp_delay: 3,  exp_width: 10};
    vecs[6] = '{gap: 3,  width: 11, tmo: 10, exp_valid: 0, exp_delay: 3,  exp_width: 10};
    vecs[7] = '{gap: 20, width: 2,  tmo: 0,  exp_valid: 1, exp_delay: 20, exp_width: 2};

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_delay",  64'(bus.measDelay), 64'd0);
    check("rst_width",  64'(bus.measWidth), 64'd0);
    check("rst_valid",  64'(bus.measValid), 64'd0);
    check("rst_tmo",    64'(bus.measTimeout), 64'd0);
    check("rst_busy",   64'(bus.busy), 64'd0);
    check("rst_missed", 64'(bus.missedEvents), 64'd0);
    check("rst_state",  64'(dbg.state), 64'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    repeat (2) tick();

    // ---------------- table-driven measurements ----------------
    for (int i = 0; i < 8; i++) begin
      v0 = valid_cnt;
      t0 = tmo_cnt;
      drive_meas(vecs[i].gap, vecs[i].width, vecs[i].tmo);
      wait_pulse($sformatf("vec%0d", i), v0, t0);
      check($sformatf("vec%0d_valid_n", i), 64'(valid_cnt - v0), 64'(vecs[i].exp_valid));
      check($sformatf("vec%0d_tmo_n", i), 64'(tmo_cnt - t0), 64'(!vecs[i].exp_valid));
      check($sformatf("vec%0d_delay", i), 64'(bus.measDelay), 64'(vecs[i].exp_delay));
      check($sformatf("vec%0d_width", i), 64'(bus.measWidth), 64'(vecs[i].exp_width));
      check($sformatf("vec%0d_busy", i), 64'(bus.busy), 64'd0);
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d_latency", i), 64'(valid_cyc - fall_cyc), 64'd1);
    end

    // ---------------- timeout at 20 with no strobe ----------------
    v0 = valid_cnt;
    t0 = tmo_cnt;
    bus.myTimeout = CW'(20);
    tick();
    bus.myEvent = 1'b1;
    ev_cyc = cyc;
    tick();
    bus.myEvent = 1'b0;
    wait_pulse("tmo20", v0, t0);
    check("tmo20_cycle", 64'(tmo_cyc - ev_cyc), 64'd21);
    check("tmo20_tmo_n", 64'(tmo_cnt - t0), 64'd1);
    check("tmo20_valid_n", 64'(valid_cnt - v0), 64'd0);
    check("tmo20_busy", 64'(bus.busy), 64'd0);
    check("tmo20_delay", 64'(bus.measDelay), 64'd20);
    check("tmo20_width", 64'(bus.measWidth), 64'd2);
    bus.myTimeout = '0;

    // ---------------- event and strobe rise together ----------------
    v0 = valid_cnt;
    t0 = tmo_cnt;
    tick();
    bus.myEvent  = 1'b1;
    bus.strobeIn = 1'b1;
    tick();
    bus.myEvent  = 1'b0;
    tick();
    bus.strobeIn = 1'b0;
    repeat (4) tick();
    bus.strobeIn = 1'b1;
    repeat (2) tick();
    bus.strobeIn = 1'b0;
    wait_pulse("same", v0, t0);
    check("same_valid_n", 64'(valid_cnt - v0), 64'd1);
    check("same_delay", 64'(bus.measDelay), 64'd6);
    check("same_width", 64'(bus.measWidth), 64'd2);

    // ---------------- events while busy, and on the return to IDLE ----------------
    v0 = valid_cnt;
    t0 = tmo_cnt;
    tick();
    bus.myEvent = 1'b1;
    tick();
    bus.myEvent = 1'b0;
    tick();
    bus.strobeIn = 1'b1;
    repeat (2) tick();
    bus.myEvent = 1'b1;
    tick();
    bus.myEvent = 1'b0;
    repeat (2) tick();
    bus.strobeIn = 1'b0;
    bus.myEvent  = 1'b1;
    tick();
    bus.myEvent  = 1'b0;
    wait_pulse("miss", v0, t0);
    check("miss_valid_n", 64'(valid_cnt - v0), 64'd1);
    check("miss_delay", 64'(bus.measDelay), 64'd2);
    check("miss_width", 64'(bus.measWidth), 64'd5);
    check("miss_count", 64'(bus.missedEvents), 64'd2);
    check("miss_not_started", 64'(bus.busy), 64'd0);

    // ---------------- async reset mid IN_PULSE ----------------
    v0 = valid_cnt;
    t0 = tmo_cnt;
    tick();
    bus.myEvent = 1'b1;
    tick();
    bus.myEvent = 1'b0;
    repeat (2) tick();
    bus.strobeIn = 1'b1;
    repeat (2) tick();
    check("pre_rst_state", 64'(dbg.state), 64'(IN_PULSE));
    #2;
    rst = 1'b1;
    #1;
    check("arst_delay",  64'(bus.measDelay), 64'd0);
    check("arst_width",  64'(bus.measWidth), 64'd0);
    check("arst_busy",   64'(bus.busy), 64'd0);
    check("arst_missed", 64'(bus.missedEvents), 64'd0);
    check("arst_state",  64'(dbg.state), 64'(IDLE));
    bus.strobeIn = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive_meas(4, 2, 0);
    wait_pulse("post_rst", v0, t0);
    check("post_rst_valid_n", 64'(valid_cnt - v0), 64'd1);
    check("post_rst_delay", 64'(bus.measDelay), 64'd4);
    check("post_rst_width", 64'(bus.measWidth), 64'd2);

    // ---------------- level high at reset release, then enable drop ----------------
    v0 = valid_cnt;
    t0 = tmo_cnt;
    @(negedge clk);
    rst = 1'b1;
    bus.myEvent = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("rel_rise_busy", 64'(bus.busy), 64'd1);
    check("rel_rise_state", 64'(dbg.state), 64'(WAIT_STROBE));
    bus.enable  = 1'b0;
    bus.myEvent = 1'b0;
    tick();
    check("en_drop_busy", 64'(bus.busy), 64'd0);
    check("en_drop_state", 64'(dbg.state), 64'(IDLE));
    repeat (4) tick();
    check("en_drop_valid_n", 64'(valid_cnt - v0), 64'd0);
    check("en_drop_tmo_n", 64'(tmo_cnt - t0), 64'd0);
    check("en_drop_delay", 64'(bus.measDelay), 64'd0);
    bus.enable = 1'b1;

    // ---------------- counter and missed-event saturation ----------------
    v0 = valid_cnt;
    t0 = tmo_cnt;
    drive_meas(300, 1, 0);
    wait_pulse("sat", v0, t0);
    check("sat_valid_n", 64'(valid_cnt - v0), 64'd1);
    check("sat_delay", 64'(bus.measDelay), 64'd255);
    check("sat_width", 64'(bus.measWidth), 64'd1);
    check("sat_missed_none", 64'(bus.missedEvents), 64'd0);

    v0 = valid_cnt;
    t0 = tmo_cnt;
    tick();
    bus.myEvent = 1'b1;
    tick();
    bus.myEvent = 1'b0;
    for (int k = 0; k < 20; k++) begin
      repeat (14) tick();
      bus.myEvent = 1'b1;
      tick();
      bus.myEvent = 1'b0;
    end
    check("hold_busy", 64'(bus.busy), 64'd1);
    check("hold_missed_sat", 64'(bus.missedEvents), 64'd15);
    check("hold_no_tmo", 64'(tmo_cnt - t0), 64'd0);
    bus.enable = 1'b0;
    tick();
    bus.enable = 1'b1;
    tick();
    check("hold_end_busy", 64'(bus.busy), 64'd0);

    check("valid_tmo_overlap", 64'(both_cnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
